// File: rtl/relogio_pkg.sv
// Shared constants, FSM states and the seven-segment encoder for the relogio display slice.
package relogio_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned NUM_FIELDS = 4;
    localparam int unsigned DIGIT_W    = 3;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned BIN_W      = 7;
    localparam int unsigned SEG_W      = 7;

    localparam int unsigned MILI_MAX   = 99;
    localparam int unsigned SEC_MAX    = 59;
    localparam int unsigned MIN_MAX    = 59;
    localparam int unsigned HOUR_MAX   = 23;

    localparam logic [BCD_W-1:0] DASH_CODE = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CONVERT,
        ST_COMMIT
    } frame_state_e;

    typedef struct packed {
        logic [6:0] mili;
        logic [5:0] second;
        logic [5:0] minute;
        logic [4:0] hour;
    } snapshot_t;

    // Segment pattern with bit 0 = a; unused codes stay blank.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_W-1:0] code);
        case (code)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            4'hA:    return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/relogio_bin2bcd.sv
// Repeated-subtraction binary to two-digit BCD converter; one subtraction of 10 per cycle.
module relogio_bin2bcd
    import relogio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units
);

    logic [BIN_W-1:0] residue;
    logic             running;

    always_ff @(posedge clk) begin
        if (rst) begin
            residue <= '0;
            tens    <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            residue <= bin;
            tens    <= '0;
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            if (residue >= 7'd10) begin
                residue <= residue - 7'd10;
                tens    <= tens + 4'd1;
            end else begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    assign units = residue[BCD_W-1:0];

endmodule

// File: rtl/relogio_display.sv
// Eight-digit multiplexed HH.MM.SS.CC display with per-frame snapshot and BCD conversion.
// Optional macro RELOGIO_DP_BLINK_EN blinks the separator points with the seconds LSB.
module relogio_display
    import relogio_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            mili,
    input  logic [5:0]            second,
    input  logic [5:0]            minute,
    input  logic [4:0]            hour,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0]   div, div_nxt;
    logic [DIGIT_W-1:0] digit, digit_nxt;
    frame_state_e       state, state_nxt;
    logic               boot;
    logic               trigger;
    snapshot_t          snap;

    logic [NUM_DIGITS-1:0][BCD_W-1:0] bank, bank_nxt;
    logic [NUM_FIELDS-1:0][BIN_W-1:0] conv_bin;
    logic [NUM_FIELDS-1:0][BCD_W-1:0] conv_tens, conv_units;
    logic [NUM_FIELDS-1:0]            conv_done;
    logic [NUM_FIELDS-1:0]            field_bad;
    logic                             conv_start;
    logic                             dp_en;
    logic [NUM_DIGITS-1:0]            an_nxt;
    logic                             dp_nxt;

    // Scan position for the next cycle.
    always_comb begin
        div_nxt   = div + DIV_W'(1);
        digit_nxt = digit;
        if (div == DIV_W'(SCAN_DIV - 1)) begin
            div_nxt   = '0;
            digit_nxt = digit + DIGIT_W'(1);
        end
    end

    assign trigger = boot || ((digit == 3'd7) && (div == DIV_W'(SCAN_DIV - 1)));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (trigger) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_CONVERT;
            ST_CONVERT: if (&conv_done) state_nxt = ST_COMMIT;
            ST_COMMIT:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Converters load straight from the inputs in the same cycle the snapshot is taken.
    assign conv_start  = (state == ST_CAPTURE);
    assign conv_bin[0] = mili;
    assign conv_bin[1] = BIN_W'(second);
    assign conv_bin[2] = BIN_W'(minute);
    assign conv_bin[3] = BIN_W'(hour);

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_conv
        relogio_bin2bcd u_conv (
            .clk   (clk),
            .rst   (rst),
            .start (conv_start),
            .bin   (conv_bin[g]),
            .done  (conv_done[g]),
            .tens  (conv_tens[g]),
            .units (conv_units[g])
        );
    end

    assign field_bad[0] = snap.mili   > 7'(MILI_MAX);
    assign field_bad[1] = snap.second > 6'(SEC_MAX);
    assign field_bad[2] = snap.minute > 6'(MIN_MAX);
    assign field_bad[3] = snap.hour   > 5'(HOUR_MAX);

    always_comb begin
        bank_nxt = bank;
        if (state == ST_COMMIT) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                bank_nxt[2*i]   = field_bad[i] ? DASH_CODE : conv_units[i];
                bank_nxt[2*i+1] = field_bad[i] ? DASH_CODE : conv_tens[i];
            end
        end
    end

`ifdef RELOGIO_DP_BLINK_EN
    logic sec_lsb, sec_lsb_nxt;
    assign sec_lsb_nxt = (state == ST_COMMIT) ? snap.second[0] : sec_lsb;
    assign dp_en       = ~sec_lsb_nxt;
    always_ff @(posedge clk) begin
        if (rst) sec_lsb <= 1'b0;
        else     sec_lsb <= sec_lsb_nxt;
    end
`else
    assign dp_en = 1'b1;
`endif

    assign an_nxt = 8'b1 << digit_nxt;
    assign dp_nxt = dp_en && (digit_nxt[0] == 1'b0) && (digit_nxt != 3'd0);

    // Outputs are registered from next-state values so seg/dp/an always move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            digit      <= '0;
            boot       <= 1'b1;
            snap       <= '0;
            bank       <= '0;
            frame_done <= 1'b0;
            an         <= {NUM_DIGITS{ACTIVE_LOW}};
            seg        <= {SEG_W{ACTIVE_LOW}};
            dp         <= ACTIVE_LOW;
        end else begin
            div        <= div_nxt;
            digit      <= digit_nxt;
            boot       <= 1'b0;
            bank       <= bank_nxt;
            frame_done <= (state == ST_COMMIT);
            if (state == ST_CAPTURE) snap <= '{mili, second, minute, hour};
            an         <= an_nxt ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg        <= seg_encode(bank_nxt[digit_nxt]) ^ {SEG_W{ACTIVE_LOW}};
            dp         <= dp_nxt ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_relogio_display.sv
// Directed self-checking bench for relogio_display with SCAN_DIV=16, ACTIVE_LOW=0.
module tb_relogio_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] mili;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    relogio_display #(.SCAN_DIV(16), .ACTIVE_LOW(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .mili       (mili),
        .second     (second),
        .minute     (minute),
        .hour       (hour),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b0111111;
            1:       return 7'b0000110;
            2:       return 7'b1011011;
            3:       return 7'b1001111;
            4:       return 7'b1100110;
            5:       return 7'b1101101;
            6:       return 7'b1111101;
            7:       return 7'b0000111;
            8:       return 7'b1111111;
            9:       return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    function automatic logic [7:0][6:0] expect_frame(input int h, input int m, input int s, input int c);
        logic [7:0][6:0] f;
        f[0] = seg_of(c % 10); f[1] = seg_of(c / 10);
        f[2] = seg_of(s % 10); f[3] = seg_of(s / 10);
        f[4] = seg_of(m % 10); f[5] = seg_of(m / 10);
        f[6] = seg_of(h % 10); f[7] = seg_of(h / 10);
        return f;
    endfunction

    task automatic set_time(input int h, input int m, input int s, input int c);
        hour = 5'(h); minute = 6'(m); second = 6'(s); mili = 7'(c);
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1'b1; break; end
        end
    endtask

    // Returns at the negedge inside the cycle where the scan wraps from digit 7 to digit 0.
    task automatic wait_capture(output bit ok);
        logic [7:0] prev;
        ok = 1'b0;
        prev = an;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (prev == 8'h80 && an == 8'h01) begin ok = 1'b1; break; end
            prev = an;
        end
    endtask

    task automatic read_frame(output logic [7:0][6:0] segs, output logic [7:0] dps, output bit ok);
        logic [7:0] seen;
        seen = '0; segs = '0; dps = '0; ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (an == (8'b1 << i) && !seen[i]) begin
                    segs[i] = seg; dps[i] = dp; seen[i] = 1'b1;
                end
            end
            if (&seen) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int got;
        rst = 1'b1;
        set_time(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (an !== 8'h00) $display("FAIL reset_an got %h want 00", an); else n_pass++;
        n_checks++; if (seg !== 7'h00) $display("FAIL reset_seg got %h want 00", seg); else n_pass++;
        n_checks++; if (dp !== 1'b0) $display("FAIL reset_dp got %b want 0", dp); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (an !== 8'h01) $display("FAIL release_an got %h want 01", an); else n_pass++;
        n_checks++; if (seg !== 7'h3F) $display("FAIL release_seg got %h want 3f", seg); else n_pass++;
        got = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (frame_done) begin got = k; break; end
        end
        n_checks++; if (got == 0) $display("FAIL first_fd got none want pulse within 14 cycles"); else n_pass++;
        @(negedge clk);
        n_checks++; if (frame_done !== 1'b0) $display("FAIL fd_width got %b want 0", frame_done); else n_pass++;
    endtask

    task automatic test_conversion;
        logic [7:0][6:0] segs, exp;
        logic [7:0] dps, exp_dp;
        bit ok;
        set_time(23, 59, 59, 99);
        wait_fd(ok);
        wait_fd(ok);
        n_checks++; if (!ok) $display("FAIL conv_fd_timeout got none want pulse"); else n_pass++;
        read_frame(segs, dps, ok);
        n_checks++; if (!ok) $display("FAIL conv_scan_timeout got partial want 8 digits"); else n_pass++;
        exp = expect_frame(23, 59, 59, 99);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (segs[i] !== exp[i]) $display("FAIL conv_digit%0d got %h want %h", i, segs[i], exp[i]);
            else n_pass++;
        end
`ifdef RELOGIO_DP_BLINK_EN
        exp_dp = 8'h00;
`else
        exp_dp = 8'h54;
`endif
        n_checks++; if (dps !== exp_dp) $display("FAIL conv_dp got %h want %h", dps, exp_dp); else n_pass++;
    endtask

    task automatic test_no_tearing;
        logic [7:0][6:0] segs, exp;
        logic [7:0] dps;
        bit ok;
        set_time(12, 34, 56, 78);
        wait_capture(ok);
        wait_capture(ok);
        n_checks++; if (!ok) $display("FAIL tear_capture_timeout got none want wrap"); else n_pass++;
        @(negedge clk);
        set_time(0, 0, 0, 0);
        wait_fd(ok);
        read_frame(segs, dps, ok);
        exp = expect_frame(12, 34, 56, 78);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (segs[i] !== exp[i]) $display("FAIL tear_digit%0d got %h want %h", i, segs[i], exp[i]);
            else n_pass++;
        end
        wait_fd(ok);
        read_frame(segs, dps, ok);
        exp = expect_frame(0, 0, 0, 0);
        n_checks++; if (segs !== exp) $display("FAIL tear_next_frame got %h want %h", segs, exp); else n_pass++;
    endtask

    task automatic test_out_of_range;
        logic [7:0][6:0] segs, exp;
        logic [7:0] dps;
        bit ok;
        set_time(30, 56, 34, 120);
        wait_fd(ok);
        wait_fd(ok);
        read_frame(segs, dps, ok);
        n_checks++; if (!ok) $display("FAIL oor_scan_timeout got partial want 8 digits"); else n_pass++;
        exp = expect_frame(0, 56, 34, 0);
        exp[0] = 7'b1000000; exp[1] = 7'b1000000;
        exp[6] = 7'b1000000; exp[7] = 7'b1000000;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (segs[i] !== exp[i]) $display("FAIL oor_digit%0d got %h want %h", i, segs[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0][6:0] segs, exp;
        logic [7:0] dps;
        bit ok;
        int got;
        set_time(12, 34, 56, 78);
        wait_capture(ok);
        wait_capture(ok);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (frame_done !== 1'b0 || an !== 8'h00)
                $display("FAIL midrst_hold%0d got fd=%b an=%h want fd=0 an=00", k, frame_done, an);
            else n_pass++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (seg !== 7'h3F) $display("FAIL midrst_bank_clear got %h want 3f", seg); else n_pass++;
        got = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (frame_done) begin got = k; break; end
        end
        n_checks++;
        if (got < 3) $display("FAIL midrst_fd_timing got cycle %0d want 3..14", got);
        else n_pass++;
        read_frame(segs, dps, ok);
        exp = expect_frame(12, 34, 56, 78);
        n_checks++; if (segs !== exp) $display("FAIL midrst_frame got %h want %h", segs, exp); else n_pass++;
    endtask

    task automatic test_dp;
        logic [7:0][6:0] segs;
        logic [7:0] dps, exp_dp;
        bit ok;
        set_time(1, 2, 6, 0);
        wait_fd(ok);
        wait_fd(ok);
        read_frame(segs, dps, ok);
        n_checks++; if (dps !== 8'h54) $display("FAIL dp_even got %h want 54", dps); else n_pass++;
        set_time(1, 2, 7, 0);
        wait_fd(ok);
        wait_fd(ok);
        read_frame(segs, dps, ok);
`ifdef RELOGIO_DP_BLINK_EN
        exp_dp = 8'h00;
`else
        exp_dp = 8'h54;
`endif
        n_checks++; if (dps !== exp_dp) $display("FAIL dp_odd got %h want %h", dps, exp_dp); else n_pass++;
        n_checks++; if (segs[2] !== 7'b0000111) $display("FAIL dp_odd_units got %h want 07", segs[2]); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        set_time(0, 0, 0, 0);
        test_reset;
        test_conversion;
        test_no_tearing;
        test_out_of_range;
        test_reset_mid;
        test_dp;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
